mul16_seq: RTL and testbench

//   Sequential unsigned 16x16->32 multiplier built on one shared 16-bit ripple adder (Adder16).
//   FSM runs shift-and-add: one conditional add plus a right shift per clock.

---
 rtl/mul16_seq_pkg.sv | 12 +
 rtl/mul16_seq_adder16.sv | 26 ++
 rtl/mul16_seq.sv | 102 ++++++++++
 tb/tb_mul16_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: FSM encoding and step count.
package mul16_seq_pkg;

    localparam int MUL_STEPS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul16_seq_adder16.sv
// 16-bit ripple-carry adder with carry-out; the single adder shared by the multiplier datapath.
module mul16_seq_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        c16
);

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_fa
            logic ci;
            logic co;
            if (i == 0) begin : g_c0
                assign ci = 1'b0;
            end else begin : g_cn
                assign ci = g_fa[i-1].co;
            end
            assign sum[i] = a[i] ^ b[i] ^ ci;
            assign co     = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
        end
    endgenerate

    assign c16 = g_fa[15].co;

endmodule

// File: rtl/mul16_seq.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier: one conditional add and one
// right shift per clock, start/done handshake, optional early exit on exhausted multiplier.
module mul16_seq
    import mul16_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);

    state_t      state, state_n;
    logic [15:0] mcand, mcand_n;
    logic [15:0] acc_hi, acc_hi_n;
    logic [15:0] acc_lo, acc_lo_n;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] p_n;

    logic [15:0] sum;
    logic        ovfl;
    logic [31:0] step;
    logic [15:0] rem_mask;
    logic        rem_zero;
    logic        last;
    logic [31:0] align;

    mul16_seq_adder16 adder16_u (
        .a   (acc_hi),
        .b   (acc_lo[0] ? mcand : 16'h0000),
        .sum (sum),
        .c16 (ovfl)
    );

    // 33-bit {carry, sum, acc_lo} shifted right by one; the carry must survive.
    assign step     = {ovfl, sum, acc_lo[15:1]};
    assign last     = (cnt == 5'(MUL_STEPS - 1));
    // Unconsumed multiplier bits sit in the low (15-cnt) bits of the shifted acc_lo.
    assign rem_mask = 16'hFFFF >> (cnt + 5'd1);
    assign rem_zero = ((step[15:0] & rem_mask) == 16'h0000);
    assign align    = step >> (5'(MUL_STEPS - 1) - cnt);

    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        acc_hi_n = acc_hi;
        acc_lo_n = acc_lo;
        cnt_n    = cnt;
        p_n      = p;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_n  = a;
                    acc_lo_n = b;
                    acc_hi_n = 16'h0000;
                    cnt_n    = 5'd0;
                    p_n      = 32'h0;
                    state_n  = ST_RUN;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_hi_n = step[31:16];
                acc_lo_n = step[15:0];
                cnt_n    = cnt + 5'd1;
                if (last || (EARLY_EXIT && rem_zero)) begin
                    p_n     = align;
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            mcand  <= 16'h0000;
            acc_hi <= 16'h0000;
            acc_lo <= 16'h0000;
            cnt    <= 5'd0;
            p      <= 32'h0;
        end else begin
            state  <= state_n;
            mcand  <= mcand_n;
            acc_hi <= acc_hi_n;
            acc_lo <= acc_lo_n;
            cnt    <= cnt_n;
            p      <= p_n;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: one instance per EARLY_EXIT value, checked against a*b and bit-length latency.
module tb_mul16_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_v [2];
    logic [15:0] a_v     [2];
    logic [15:0] b_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [31:0] p_v     [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mul16_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .p(p_v[0])
    );

    mul16_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .p(p_v[1])
    );

    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    // Steps spent in RUN: always 16, or the multiplier's bit length (min 1) with early exit.
    function automatic int ref_steps(input int idx, input logic [15:0] y);
        int n;
        if (idx == 0) return 16;
        n = 1;
        for (int i = 0; i < 16; i++) if (y[i]) n = i + 1;
        return n;
    endfunction

    // Busy and done must never overlap on either instance.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (busy_v[k] && done_v[k]) begin
                    errors++;
                    $display("FAIL busy_done_overlap dut%0d: busy=%b done=%b, required not both 1", k, busy_v[k], done_v[k]);
                end
            end
        end
    end

    // Launch one op; cyc counts negedges from accept to the done cycle inclusive.
    task automatic run_op(input int idx, input logic [15:0] x, input logic [15:0] y,
                          output logic [31:0] got, output int cyc, output int bcyc);
        @(negedge clock);
        start_v[idx] = 1'b1; a_v[idx] = x; b_v[idx] = y;
        @(negedge clock);
        start_v[idx] = 1'b0; a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom);
        cyc = 1; bcyc = 0;
        while (!done_v[idx] && cyc < 40) begin
            if (busy_v[idx]) bcyc++;
            @(negedge clock);
            cyc++;
        end
        got = p_v[idx];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b1; a_v[k] = 16'h00FF; b_v[k] = 16'h00FF;
        end
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || p_v[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b done=%b p=%h, required 0 0 00000000", k, busy_v[k], done_v[k], p_v[k]);
            end
            start_v[k] = 1'b0;
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [31:0] got; int cyc, bcyc;
        for (int k = 0; k < 2; k++) begin
            run_op(k, 16'd3, 16'd5, got, cyc, bcyc);
            checks++;
            if (got !== 32'h0000000F) begin
                errors++; $display("FAIL basic_p dut%0d: p=%h, required 0000000f", k, got);
            end
            checks++;
            if (cyc != ref_steps(k, 16'd5) + 1 || bcyc != ref_steps(k, 16'd5)) begin
                errors++; $display("FAIL basic_latency dut%0d: cycles=%0d busy=%0d, required %0d %0d",
                                   k, cyc, bcyc, ref_steps(k, 16'd5) + 1, ref_steps(k, 16'd5));
            end
        end
    endtask

    task automatic test_carry();
        logic [31:0] got; int cyc, bcyc;
        for (int k = 0; k < 2; k++) begin
            run_op(k, 16'hFFFF, 16'hFFFF, got, cyc, bcyc);
            checks++;
            if (got !== 32'hFFFE0001 || cyc != 17) begin
                errors++; $display("FAIL carry dut%0d: p=%h cycles=%0d, required fffe0001 17", k, got, cyc);
            end
            repeat (3) @(negedge clock);
            checks++;
            if (p_v[k] !== 32'hFFFE0001 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
                errors++; $display("FAIL hold dut%0d: p=%h busy=%b done=%b, required fffe0001 0 0", k, p_v[k], busy_v[k], done_v[k]);
            end
        end
    endtask

    task automatic test_zero();
        logic [31:0] got; int cyc, bcyc;
        for (int k = 0; k < 2; k++) begin
            run_op(k, 16'h1234, 16'h0000, got, cyc, bcyc);
            checks++;
            if (got !== 32'h0 || cyc != ref_steps(k, 16'h0) + 1) begin
                errors++; $display("FAIL zero dut%0d: p=%h cycles=%0d, required 00000000 %0d", k, got, cyc, ref_steps(k, 16'h0) + 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        @(negedge clock);
        start_v[0] = 1'b1; a_v[0] = 16'd7; b_v[0] = 16'd9;
        @(negedge clock);
        start_v[0] = 1'b0;
        cyc = 1;
        while (!done_v[0] && cyc < 40) begin
            @(negedge clock);
            cyc++;
            start_v[0] = (cyc == 5);
            if (cyc == 5) begin a_v[0] = 16'd1; b_v[0] = 16'd1; end
        end
        start_v[0] = 1'b0;
        checks++;
        if (p_v[0] !== 32'd63 || cyc != 17) begin
            errors++; $display("FAIL ignore_start: p=%0d cycles=%0d, required 63 17", p_v[0], cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got; int cyc, bcyc;
        logic [15:0] x, y;
        @(negedge clock);
        start_v[0] = 1'b1; a_v[0] = 16'hABCD; b_v[0] = 16'h1357;
        @(negedge clock);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || p_v[0] !== 32'h0) begin
            errors++; $display("FAIL reset_mid: busy=%b done=%b p=%h, required 0 0 00000000", busy_v[0], done_v[0], p_v[0]);
        end
        x = 16'($urandom); y = 16'($urandom);
        run_op(0, x, y, got, cyc, bcyc);
        checks++;
        if (got !== ref_prod(x, y)) begin
            errors++; $display("FAIL after_reset: p=%h, required %h", got, ref_prod(x, y));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got; int cyc, bcyc;
        for (int k = 0; k < 2; k++) begin
            run_op(k, 16'd5, 16'd5, got, cyc, bcyc);
            // Still in the done cycle: request the next op right now.
            start_v[k] = 1'b1; a_v[k] = 16'd2; b_v[k] = 16'd21;
            checks++;
            if (done_v[k] !== 1'b1 || p_v[k] !== 32'd25) begin
                errors++; $display("FAIL b2b_prev dut%0d: done=%b p=%0d, required 1 25", k, done_v[k], p_v[k]);
            end
            @(negedge clock);
            start_v[k] = 1'b0;
            checks++;
            if (busy_v[k] !== 1'b1) begin
                errors++; $display("FAIL b2b_accept dut%0d: busy=%b, required 1", k, busy_v[k]);
            end
            cyc = 1;
            while (!done_v[k] && cyc < 40) begin
                @(negedge clock);
                cyc++;
            end
            checks++;
            if (p_v[k] !== 32'd42 || cyc != ref_steps(k, 16'd21) + 1) begin
                errors++; $display("FAIL b2b dut%0d: p=%0d cycles=%0d, required 42 %0d", k, p_v[k], cyc, ref_steps(k, 16'd21) + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] got; int cyc, bcyc;
        logic [15:0] x, y;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 1200; n++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: y = y >> $urandom_range(0, 15);
                    1: x = 16'hFFFF;
                    default: ;
                endcase
                run_op(k, x, y, got, cyc, bcyc);
                checks++;
                if (got !== ref_prod(x, y) || cyc != ref_steps(k, y) + 1 || bcyc != ref_steps(k, y)) begin
                    errors++;
                    $display("FAIL random dut%0d a=%h b=%h: p=%h cycles=%0d busy=%0d, required %h %0d %0d",
                             k, x, y, got, cyc, bcyc, ref_prod(x, y), ref_steps(k, y) + 1, ref_steps(k, y));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b0; a_v[k] = 16'h0; b_v[k] = 16'h0;
        end
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
